// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: six-state instruction sequencer with
// opcode decode for a small MIPS-like instruction set.
// Optional build macro MULTICYCLE_CTRL_MEMWAIT_EN adds a mem_ready input.
// While mem_ready is low, the MEM state holds with all outputs unchanged.
//
// state | meaning
// ------+---------------------------------------------------------------
// IF    | instruction fetch, IR written
// ID    | decode, opcode latched into op_q on exit
// EXE   | execute / branch resolve
// MEM   | data memory access (lw read, sw write)
// WB    | register file write-back
// HALT  | stopped until reset
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       zero,
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWre,
    output logic       IRWre,
    output logic       ALUSrcB,
    output logic       ALUM2Reg,
    output logic       RegWre,
    output logic       InsMemRW,
    output logic       DataMemRW,
    output logic       ExtSel,
    output logic       PCSrc,
    output logic       RegOut,
    output logic       halted,
    output logic [2:0] ALUOp,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       op_known;
    logic       mem_done;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    // Recognised-opcode check on the live opcode, used only while in ID.
    always_comb begin
        op_known = opCode inside {OP_ADD, OP_ADDI, OP_SUB, OP_ORI, OP_AND,
                                  OP_OR, OP_SW, OP_LW, OP_BEQ, OP_HALT};
    end

    // Next-state logic; reset is applied in the register, not here, so that
    // PCWre reflects the instruction flow rather than an external abort.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID: begin
                if (opCode == OP_HALT)
                    state_d = S_HALT;
                else if (!op_known)
                    state_d = S_IF;
                else
                    state_d = S_EXE;
            end
            S_EXE: begin
                if (op_q == OP_BEQ)
                    state_d = S_IF;
                else if (op_q == OP_SW || op_q == OP_LW)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (!mem_done)
                    state_d = S_MEM;
                else if (op_q == OP_LW)
                    state_d = S_WB;
                else
                    state_d = S_IF;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // State and latched opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID)
                op_q <= opCode;
        end
    end

    // Per-state strobes and op_q-based datapath decode.
    always_comb begin
        IRWre     = (state_q == S_IF);
        PCWre     = (state_d == S_IF) && (state_q != S_HALT);
        RegWre    = (state_q == S_WB);
        DataMemRW = (state_q == S_MEM) && (op_q == OP_SW);
        PCSrc     = (state_q == S_EXE) && (op_q == OP_BEQ) && zero;
        halted    = (state_q == S_HALT);
        InsMemRW  = 1'b0;
        ALUSrcB   = op_q inside {OP_ADDI, OP_ORI, OP_SW, OP_LW};
        ALUM2Reg  = (op_q == OP_LW);
        ExtSel    = (op_q != OP_ORI);
        RegOut    = !(op_q inside {OP_ADDI, OP_ORI, OP_LW});
        ALUOp     = 3'b000;
        case (op_q)
            OP_SUB, OP_BEQ: ALUOp = 3'b001;
            OP_ORI, OP_OR:  ALUOp = 3'b011;
            OP_AND:         ALUOp = 3'b100;
            default:        ALUOp = 3'b000;
        endcase
        state = state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver expands each instruction
// into its expected per-cycle state walk and output values, and a negedge
// monitor compares the DUT against the queued expectations.
module tb_multicycle_ctrl;

    localparam logic [2:0] T_IF = 3'd0, T_ID = 3'd1, T_EXE = 3'd2,
                           T_MEM = 3'd3, T_WB = 3'd4, T_HALT = 3'd5;
    localparam logic [5:0] BEQ = 6'b110000, SW = 6'b100110, LW = 6'b100111,
                           HLT = 6'b111111;
    localparam int K_ALU = 0, K_BEQ = 1, K_SW = 2, K_LW = 3, K_BAD = 4, K_HALT = 5;

    typedef struct {
        logic [2:0] st;
        logic       pcwre, irwre, regwre, dmw, pcsrc, halted;
        logic       alusrcb, alum2reg, extsel, regout;
        logic [2:0] aluop;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] opCode;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    logic       mem_ready;
`endif
    logic       PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW, DataMemRW;
    logic       ExtSel, PCSrc, RegOut, halted;
    logic [2:0] ALUOp, state;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    logic [5:0] prev_op;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opCode(opCode), .zero(zero),
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
        .mem_ready(mem_ready),
`endif
        .PCWre(PCWre), .IRWre(IRWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
        .RegWre(RegWre), .InsMemRW(InsMemRW), .DataMemRW(DataMemRW),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .RegOut(RegOut), .halted(halted),
        .ALUOp(ALUOp), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int klass(input logic [5:0] op);
        if (op == HLT) return K_HALT;
        if (op == BEQ) return K_BEQ;
        if (op == SW)  return K_SW;
        if (op == LW)  return K_LW;
        if (op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010})
            return K_ALU;
        return K_BAD;
    endfunction

    // Datapath control values that follow purely from the instruction in effect.
    function automatic exp_t decode(input logic [5:0] dop);
        exp_t e;
        e = '{default: '0};
        e.alusrcb  = dop inside {6'b000001, 6'b010000, SW, LW};
        e.alum2reg = (dop == LW);
        e.extsel   = (dop != 6'b010000);
        e.regout   = !(dop inside {6'b000001, 6'b010000, LW});
        if (dop == 6'b000010 || dop == BEQ)      e.aluop = 3'b001;
        else if (dop == 6'b010000 || dop == 6'b010010) e.aluop = 3'b011;
        else if (dop == 6'b010001)               e.aluop = 3'b100;
        else                                     e.aluop = 3'b000;
        return e;
    endfunction

    // Drive one instruction; abort_at >= 0 asserts reset during that cycle.
    // zexe: 0/1 forces zero in EXE, 2 randomises it.
    task automatic run_instr(input logic [5:0] op, input int abort_at,
                             input int zexe, input int mem_wait, input int halt_cycles);
        logic [2:0] seq[$];
        int         k, mw;
        exp_t       e;
        logic [5:0] dop;
        mw = mem_wait;
`ifndef MULTICYCLE_CTRL_MEMWAIT_EN
        mw = 0;
`endif
        k = klass(op);
        seq.push_back(T_IF);
        seq.push_back(T_ID);
        if (k == K_ALU) begin
            seq.push_back(T_EXE); seq.push_back(T_WB);
        end else if (k == K_BEQ) begin
            seq.push_back(T_EXE);
        end else if (k == K_SW || k == K_LW) begin
            seq.push_back(T_EXE);
            for (int j = 0; j <= mw; j++) seq.push_back(T_MEM);
            if (k == K_LW) seq.push_back(T_WB);
        end else if (k == K_HALT) begin
            for (int j = 0; j < halt_cycles; j++) seq.push_back(T_HALT);
        end
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk);
            #1;
            reset  = (i == abort_at);
            opCode = (seq[i] == T_ID) ? op : 6'($urandom_range(63));
            if (seq[i] == T_EXE && zexe != 2) zero = 1'(zexe);
            else                              zero = 1'($urandom_range(1));
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
            if (seq[i] == T_MEM)
                mem_ready = !(i + 1 < seq.size() && seq[i+1] == T_MEM);
            else
                mem_ready = 1'($urandom_range(1));
`endif
            dop      = (i < 2) ? prev_op : op;
            e        = decode(dop);
            e.st     = seq[i];
            e.irwre  = (seq[i] == T_IF);
            e.pcwre  = (i == seq.size() - 1) && (k != K_HALT);
            e.regwre = (seq[i] == T_WB);
            e.dmw    = (seq[i] == T_MEM) && (op == SW);
            e.pcsrc  = (seq[i] == T_EXE) && (op == BEQ) && zero;
            e.halted = (seq[i] == T_HALT);
            sbq.push_back(e);
            if (i == abort_at) break;
        end
        prev_op = (abort_at >= 0 && abort_at < seq.size()) ? 6'b000000 : op;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("state",     state,     e.st);
                chk("PCWre",     PCWre,     e.pcwre);
                chk("IRWre",     IRWre,     e.irwre);
                chk("RegWre",    RegWre,    e.regwre);
                chk("DataMemRW", DataMemRW, e.dmw);
                chk("PCSrc",     PCSrc,     e.pcsrc);
                chk("halted",    halted,    e.halted);
                chk("ALUSrcB",   ALUSrcB,   e.alusrcb);
                chk("ALUM2Reg",  ALUM2Reg,  e.alum2reg);
                chk("ExtSel",    ExtSel,    e.extsel);
                chk("RegOut",    RegOut,    e.regout);
                chk("ALUOp",     ALUOp,     e.aluop);
                chk("InsMemRW",  InsMemRW,  0);
            end
        end
    end

    // Stimulus: directed scenarios followed by a random instruction stream.
    initial begin
        logic [5:0] pool[10];
        logic [5:0] op;
        int         mw, hc;
        pool = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                 6'b010010, SW, LW, BEQ, HLT};
        reset   = 1'b1;
        opCode  = 6'b000000;
        zero    = 1'b0;
        prev_op = 6'b000000;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);

        run_instr(6'b000000, -1, 2, 0, 0);
        run_instr(BEQ, -1, 1, 0, 0);
        run_instr(BEQ, -1, 0, 0, 0);
        run_instr(LW, -1, 2, 0, 0);
        run_instr(SW, -1, 2, 0, 0);
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
        run_instr(LW, -1, 2, 3, 0);
`endif
        run_instr(HLT, 13, 2, 0, 12);
        run_instr(6'b101010, -1, 2, 0, 0);
        run_instr(SW, 3, 2, 0, 0);
        run_instr(6'b010000, -1, 2, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(10) == 10) op = 6'($urandom_range(63));
            else                          op = pool[$urandom_range(9)];
            mw = $urandom_range(3);
            if (op == HLT) begin
                hc = $urandom_range(14, 10);
                run_instr(op, 2 + hc - 1, 2, 0, hc);
            end else if ($urandom_range(7) == 0) begin
                run_instr(op, $urandom_range(6), 2, mw, 0);
            end else begin
                run_instr(op, -1, 2, mw, 0);
            end
        end

        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
